id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline stage that sits directly upstream of the ALU in the 5-stage MIPS core. It registers decoded operands and control signals from ID and maps `alu_op`/`funct` onto the 6-bit ALU selection code. Each cycle it presents forwarded `op1`/`op2` to the ALU. It also detects load-use hazards and applies hold, flush and bubble insertion.

## Interface
- `REG_ADDR_W`, 5: register index width
- `DATA_W`, 32: datapath width
- `clk` in 1: clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `hold` in 1: downstream stall; freeze this stage
- `flush` in 1: squash the instruction being loaded (branch taken)
- `id_valid` in 1: ID holds a real instruction
- `id_rs_data`, `id_rt_data` in DATA_W: register-file read data
- `id_imm` in DATA_W: sign-extended immediate
- `id_rs`, `id_rt`, `id_rd` in REG_ADDR_W: register indices
- `id_funct` in 6: R-type funct field
- `id_alu_op` in 2: 00 add, 01 sub, 10 use funct, 11 slt
- `id_alu_src`, `id_reg_dst`, `id_reg_write`, `id_mem_read`, `id_mem_write`, `id_mem_to_reg` in 1: decode control
- `exmem_reg_write` in 1, `exmem_rd` in REG_ADDR_W, `exmem_result` in DATA_W: EX/MEM writeback info
- `memwb_reg_write` in 1, `memwb_rd` in REG_ADDR_W, `memwb_result` in DATA_W: MEM/WB writeback info
- `hazard_stall` out 1: freeze PC and IF/ID (combinational)
- `ex_valid` out 1: EX holds a real instruction
- `op1`, `op2` out DATA_W: ALU operands (combinational)
- `selection` out 6: ALU function code (registered)
- `ex_store_data` out DATA_W: forwarded rt value, used by sw
- `ex_dest` out REG_ADDR_W: destination register, `reg_dst ? rd : rt`
- `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_mem_to_reg` out 1: registered control

## Operation
- Per-edge priority: `flush` > `hold` > `hazard_stall` > normal load.
  - `flush`: load a bubble.
  - `hold`: keep all registers unchanged.
  - `hazard_stall`: load a bubble.
  - Normal load: load the ID inputs.
- Bubble: `ex_valid`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write` and `ex_mem_to_reg` = 0; data registers don't-care.
- Selection mapping, resolved at load time:
  - 00 → 100000
  - 01 → 100010
  - 10 → `id_funct`
  - 11 → 101010
- `hazard_stall` = `ex_valid & ex_mem_read & (ex_dest != 0) & (ex_dest == id_rs | (ex_dest == id_rt & !id_alu_src))`, gated by `id_valid`.
- Forwarding applies to both the rs and rt paths:
  - EX/MEM match: use `exmem_result`.
  - Else MEM/WB match: use `memwb_result`.
  - Else use the registered register data.
- A match requires writer `reg_write` = 1, rd equal to the source index, and rd != 0. Register $0 is never forwarded.
- `op1` = forwarded rs.
- `op2` = `alu_src ? imm : forwarded rt`.
- `ex_store_data` = forwarded rt.

## Timing
- Reset values:
  - All registered outputs 0.
  - `selection` = 100000.
  - `op1`/`op2` = 0 (derived from cleared registers with no writers active).
- Reset is honoured mid-operation on assertion, with no clock edge required.
- Latency: ID inputs appear on registered outputs one edge after a normal load.
- `op1`, `op2`, `ex_store_data` and `hazard_stall` are combinational in the same cycle. They may therefore change while `hold` is high, as the writers advance.
- Load-use inserts exactly one bubble. On the next cycle the load is in MEM, and the value forwards from MEM/WB one cycle later through the normal path.
- `flush` together with `hazard_stall`: a bubble is loaded, and `hazard_stall` still freezes IF/ID.

## Configuration
- `FORWARDING_EN` defined:
  - Forwarding behaves as described above.
  - `hazard_stall` covers load-use only.
- `FORWARDING_EN` undefined:
  - `op1`/`ex_store_data` take the registered data directly.
  - `hazard_stall` asserts for any RAW match against the EX stage (`ex_reg_write`) or the EX/MEM writer.
  - MEM/WB needs no stall; the register file writes first and reads second.

## Structure
- Shared package `mips_pkg` holds:
  - funct constants: `FN_ADD`, `FN_SUB`, `FN_AND`, `FN_OR`, `FN_XOR`, `FN_NOR`, `FN_SLT`
  - `alu_op` encodings
  - `DATA_W`/`REG_ADDR_W`
- One sub-module, `fwd_mux`: a 3:1 priority forwarding selector. It is instantiated twice, for rs and rt.

## Test plan
- Reset:
  - Assert `rst` mid-stream → `ex_valid` = 0 and `selection` = 100000 immediately, with no edge.
- R-type sub:
  - Stimulus: alu_op = 10, funct = 100010, rs_data = 9, rt_data = 4.
  - Response: next cycle `selection` = 100010, `op1` = 9, `op2` = 4.
- Forwarding priority:
  - Stimulus: exmem rd = 3 / result 0xAA, memwb rd = 3 / result 0xBB, rs = 3.
  - Response: `op1` = 0xAA.
  - With rd = 0 instead, `op1` = the register data.
- Load-use:
  - Stimulus: lw to $5 in EX, next instruction reads $5.
  - Response: `hazard_stall` = 1 for one cycle, then a bubble (`ex_valid` = 0), then `op1` = memwb_result.
- Hold and flush:
  - `hold` for 3 cycles: outputs frozen.
  - `flush` + `hold` together: bubble loaded.
- Without `FORWARDING_EN`:
  - Stimulus: add writes $2 (in EX), next instruction reads $2.
  - Response: `hazard_stall` = 1 until the writer leaves EX/MEM.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS core types: datapath widths, R-type funct codes, alu_op encodings.
// Pure declarations; no timing or backpressure of its own.
package mips_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10,
        ALU_SLT   = 2'b11
    } alu_op_e;

    typedef struct packed {
        logic valid;
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
    } ex_ctrl_t;

    function automatic logic [5:0] alu_selection(input logic [1:0] alu_op, input logic [5:0] funct);
        case (alu_op)
            ALU_ADD:   return FN_ADD;
            ALU_SUB:   return FN_SUB;
            ALU_FUNCT: return funct;
            default:   return FN_SLT;
        endcase
    endfunction

    // True when writer index rd is a live source of the instruction (rt only counts without an immediate).
    function automatic logic reads_reg(input logic [REG_ADDR_W-1:0] rd, input logic [REG_ADDR_W-1:0] rs,
                                       input logic [REG_ADDR_W-1:0] rt, input logic alu_src);
        return (rd != '0) && ((rd == rs) || ((rd == rt) && !alu_src));
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decode inputs, writeback snoop ports and ALU-facing outputs.
// master = ID/pipeline side driving the stage, slave = the id_ex_stage itself.
interface id_ex_stage_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  hold;
    logic                  flush;
    logic                  id_valid;
    logic [DATA_W-1:0]     id_rs_data;
    logic [DATA_W-1:0]     id_rt_data;
    logic [DATA_W-1:0]     id_imm;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic [REG_ADDR_W-1:0] id_rd;
    logic [5:0]            id_funct;
    logic [1:0]            id_alu_op;
    logic                  id_alu_src;
    logic                  id_reg_dst;
    logic                  id_reg_write;
    logic                  id_mem_read;
    logic                  id_mem_write;
    logic                  id_mem_to_reg;
    logic                  exmem_reg_write;
    logic [REG_ADDR_W-1:0] exmem_rd;
    logic [DATA_W-1:0]     exmem_result;
    logic                  memwb_reg_write;
    logic [REG_ADDR_W-1:0] memwb_rd;
    logic [DATA_W-1:0]     memwb_result;
    logic                  hazard_stall;
    logic                  ex_valid;
    logic [DATA_W-1:0]     op1;
    logic [DATA_W-1:0]     op2;
    logic [5:0]            selection;
    logic [DATA_W-1:0]     ex_store_data;
    logic [REG_ADDR_W-1:0] ex_dest;
    logic                  ex_reg_write;
    logic                  ex_mem_read;
    logic                  ex_mem_write;
    logic                  ex_mem_to_reg;

    modport master (
        output hold, flush, id_valid, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
               id_funct, id_alu_op, id_alu_src, id_reg_dst, id_reg_write, id_mem_read,
               id_mem_write, id_mem_to_reg, exmem_reg_write, exmem_rd, exmem_result,
               memwb_reg_write, memwb_rd, memwb_result,
        input  hazard_stall, ex_valid, op1, op2, selection, ex_store_data, ex_dest,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg
    );

    modport slave (
        input  hold, flush, id_valid, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
               id_funct, id_alu_op, id_alu_src, id_reg_dst, id_reg_write, id_mem_read,
               id_mem_write, id_mem_to_reg, exmem_reg_write, exmem_rd, exmem_result,
               memwb_reg_write, memwb_rd, memwb_result,
        output hazard_stall, ex_valid, op1, op2, selection, ex_store_data, ex_dest,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg
    );
endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// 3:1 priority operand forwarding: EX/MEM writer, then MEM/WB writer, then register data.
// Purely combinational; no state, no backpressure.
module fwd_mux #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] src,
    input  logic [DATA_W-1:0]     reg_data,
    input  logic                  exmem_we,
    input  logic [REG_ADDR_W-1:0] exmem_rd,
    input  logic [DATA_W-1:0]     exmem_result,
    input  logic                  memwb_we,
    input  logic [REG_ADDR_W-1:0] memwb_rd,
    input  logic [DATA_W-1:0]     memwb_result,
    output logic [DATA_W-1:0]     data
);
    always_comb begin
        data = reg_data;
        if (memwb_we && (memwb_rd == src) && (src != '0))
            data = memwb_result;
        if (exmem_we && (exmem_rd == src) && (src != '0))
            data = exmem_result;
    end
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX register + ALU selection decode + forwarding/hazard detect (FORWARDING_EN enables bypassing).
// Latency: one edge ID->EX; priority flush > hold > hazard bubble > load; op1/op2/hazard_stall combinational.
module id_ex_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic         clk,
    input  logic         rst,
    id_ex_stage_if.slave bus
);
    import mips_pkg::*;

    ex_ctrl_t              ex_ctrl;
    logic                  ex_alu_src;
    logic [DATA_W-1:0]     ex_rs_data;
    logic [DATA_W-1:0]     ex_rt_data;
    logic [DATA_W-1:0]     ex_imm;
    logic [REG_ADDR_W-1:0] ex_rs;
    logic [REG_ADDR_W-1:0] ex_rt;
    logic [REG_ADDR_W-1:0] ex_dest;
    logic [5:0]            ex_sel;
    logic                  hazard_stall;
    logic                  exmem_fwd_we;
    logic                  memwb_fwd_we;
    logic [DATA_W-1:0]     rs_fwd;
    logic [DATA_W-1:0]     rt_fwd;

`ifdef FORWARDING_EN
    assign exmem_fwd_we = bus.exmem_reg_write;
    assign memwb_fwd_we = bus.memwb_reg_write;
    // Only a load in EX cannot be bypassed in time.
    assign hazard_stall = bus.id_valid & ex_ctrl.valid & ex_ctrl.mem_read &
                          reads_reg(ex_dest, bus.id_rs, bus.id_rt, bus.id_alu_src);
`else
    assign exmem_fwd_we = 1'b0;
    assign memwb_fwd_we = 1'b0;
    // MEM/WB is covered by write-before-read in the register file.
    assign hazard_stall = bus.id_valid &
                          ((ex_ctrl.valid & ex_ctrl.reg_write &
                            reads_reg(ex_dest, bus.id_rs, bus.id_rt, bus.id_alu_src)) |
                           (bus.exmem_reg_write &
                            reads_reg(bus.exmem_rd, bus.id_rs, bus.id_rt, bus.id_alu_src)));
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_ctrl    <= '0;
            ex_alu_src <= 1'b0;
            ex_rs_data <= '0;
            ex_rt_data <= '0;
            ex_imm     <= '0;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_dest    <= '0;
            ex_sel     <= FN_ADD;
        end else if (bus.flush) begin
            ex_ctrl <= '0;
        end else if (!bus.hold) begin
            if (hazard_stall) begin
                ex_ctrl <= '0;
            end else begin
                ex_ctrl    <= '{valid: bus.id_valid, reg_write: bus.id_reg_write,
                                mem_read: bus.id_mem_read, mem_write: bus.id_mem_write,
                                mem_to_reg: bus.id_mem_to_reg};
                ex_alu_src <= bus.id_alu_src;
                ex_rs_data <= bus.id_rs_data;
                ex_rt_data <= bus.id_rt_data;
                ex_imm     <= bus.id_imm;
                ex_rs      <= bus.id_rs;
                ex_rt      <= bus.id_rt;
                ex_dest    <= bus.id_reg_dst ? bus.id_rd : bus.id_rt;
                ex_sel     <= alu_selection(bus.id_alu_op, bus.id_funct);
            end
        end
    end

    fwd_mux #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs (
        .src(ex_rs), .reg_data(ex_rs_data),
        .exmem_we(exmem_fwd_we), .exmem_rd(bus.exmem_rd), .exmem_result(bus.exmem_result),
        .memwb_we(memwb_fwd_we), .memwb_rd(bus.memwb_rd), .memwb_result(bus.memwb_result),
        .data(rs_fwd)
    );

    fwd_mux #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rt (
        .src(ex_rt), .reg_data(ex_rt_data),
        .exmem_we(exmem_fwd_we), .exmem_rd(bus.exmem_rd), .exmem_result(bus.exmem_result),
        .memwb_we(memwb_fwd_we), .memwb_rd(bus.memwb_rd), .memwb_result(bus.memwb_result),
        .data(rt_fwd)
    );

    assign bus.hazard_stall  = hazard_stall;
    assign bus.ex_valid      = ex_ctrl.valid;
    assign bus.ex_reg_write  = ex_ctrl.reg_write;
    assign bus.ex_mem_read   = ex_ctrl.mem_read;
    assign bus.ex_mem_write  = ex_ctrl.mem_write;
    assign bus.ex_mem_to_reg = ex_ctrl.mem_to_reg;
    assign bus.ex_dest       = ex_dest;
    assign bus.selection     = ex_sel;
    assign bus.op1           = rs_fwd;
    assign bus.op2           = ex_alu_src ? ex_imm : rt_fwd;
    assign bus.ex_store_data = rt_fwd;
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed pipeline scenarios followed by random traffic against an instruction-level model.
module tb_id_ex_stage;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_ex_stage_if bus ();
    id_ex_stage dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    int total  = 0;
    int passed = 0;

    // The instruction currently sitting in EX, as the rules say it should be.
    typedef struct packed {
        bit          valid, rw, mr, mw, m2r, alu_src, known;
        logic [31:0] rs_d, rt_d, imm;
        logic [4:0]  rs, rt, dest;
        logic [5:0]  sel;
    } ex_t;
    ex_t m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [5:0] sel_of(input logic [1:0] op, input logic [5:0] funct);
        logic [5:0] tab [4];
        tab = '{6'b100000, 6'b100010, 6'b000000, 6'b101010};
        return (op == 2'd2) ? funct : tab[op];
    endfunction

    function automatic bit uses(input logic [4:0] d);
        return (d != 0) && ((d == bus.id_rs) || ((d == bus.id_rt) && !bus.id_alu_src));
    endfunction

    function automatic bit exp_stall();
        if (!bus.id_valid) return 1'b0;
        if (FWD) return m.valid && m.mr && uses(m.dest);
        return (m.valid && m.rw && uses(m.dest)) || (bus.exmem_reg_write && uses(bus.exmem_rd));
    endfunction

    function automatic logic [31:0] fwd_val(input logic [4:0] idx, input logic [31:0] regv);
        if (FWD && idx != 0 && bus.exmem_reg_write && bus.exmem_rd == idx) return bus.exmem_result;
        if (FWD && idx != 0 && bus.memwb_reg_write && bus.memwb_rd == idx) return bus.memwb_result;
        return regv;
    endfunction

    task automatic model_reset();
        m = '0;
        m.sel = 6'b100000;
        m.known = 1'b1;
    endtask

    task automatic clear();
        bus.hold = 0; bus.flush = 0; bus.id_valid = 0;
        bus.id_rs_data = 0; bus.id_rt_data = 0; bus.id_imm = 0;
        bus.id_rs = 0; bus.id_rt = 0; bus.id_rd = 0; bus.id_funct = 0; bus.id_alu_op = 0;
        bus.id_alu_src = 0; bus.id_reg_dst = 0; bus.id_reg_write = 0;
        bus.id_mem_read = 0; bus.id_mem_write = 0; bus.id_mem_to_reg = 0;
        bus.exmem_reg_write = 0; bus.exmem_rd = 0; bus.exmem_result = 0;
        bus.memwb_reg_write = 0; bus.memwb_rd = 0; bus.memwb_result = 0;
    endtask

    task automatic chk_all();
        chk("hazard_stall", {31'd0, bus.hazard_stall}, {31'd0, exp_stall()});
        chk("ex_valid", {31'd0, bus.ex_valid}, {31'd0, m.valid});
        chk("ex_reg_write", {31'd0, bus.ex_reg_write}, {31'd0, m.rw});
        chk("ex_mem_read", {31'd0, bus.ex_mem_read}, {31'd0, m.mr});
        chk("ex_mem_write", {31'd0, bus.ex_mem_write}, {31'd0, m.mw});
        chk("ex_mem_to_reg", {31'd0, bus.ex_mem_to_reg}, {31'd0, m.m2r});
        if (m.known) begin
            chk("selection", {26'd0, bus.selection}, {26'd0, m.sel});
            chk("ex_dest", {27'd0, bus.ex_dest}, {27'd0, m.dest});
            chk("op1", bus.op1, fwd_val(m.rs, m.rs_d));
            chk("op2", bus.op2, m.alu_src ? m.imm : fwd_val(m.rt, m.rt_d));
            chk("ex_store_data", bus.ex_store_data, fwd_val(m.rt, m.rt_d));
        end
    endtask

    // Advance one clock edge; the model follows the flush > hold > stall > load priority.
    task automatic step();
        ex_t n;
        n = m;
        if (bus.flush || (!bus.hold && exp_stall())) begin
            n.valid = 0; n.rw = 0; n.mr = 0; n.mw = 0; n.m2r = 0; n.known = 0;
        end else if (!bus.hold) begin
            n.valid = bus.id_valid; n.rw = bus.id_reg_write; n.mr = bus.id_mem_read;
            n.mw = bus.id_mem_write; n.m2r = bus.id_mem_to_reg; n.alu_src = bus.id_alu_src;
            n.rs_d = bus.id_rs_data; n.rt_d = bus.id_rt_data; n.imm = bus.id_imm;
            n.rs = bus.id_rs; n.rt = bus.id_rt;
            n.dest = bus.id_reg_dst ? bus.id_rd : bus.id_rt;
            n.sel = sel_of(bus.id_alu_op, bus.id_funct);
            n.known = 1'b1;
        end
        @(posedge clk);
        m = n;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        clear();
        model_reset();
        #12;
        chk_all();
        chk("reset_selection", {26'd0, bus.selection}, 32'h20);
        chk("reset_op1", bus.op1, 32'h0);
        rst = 1'b0;
        step();

        // R-type sub
        bus.id_valid = 1; bus.id_alu_op = 2'b10; bus.id_funct = 6'b100010;
        bus.id_rs = 1; bus.id_rt = 2; bus.id_rd = 3; bus.id_reg_dst = 1; bus.id_reg_write = 1;
        bus.id_rs_data = 9; bus.id_rt_data = 4;
        #1 chk_all();
        step();
        clear();
        #1 chk_all();
        chk("sub_selection", {26'd0, bus.selection}, 32'b100010);
        chk("sub_op1", bus.op1, 32'd9);
        chk("sub_op2", bus.op2, 32'd4);
        step();

        // Forwarding priority
        bus.id_valid = 1; bus.id_rs = 3; bus.id_rt = 3; bus.id_rs_data = 32'h11; bus.id_rt_data = 32'h22;
        #1 chk_all();
        step();
        clear();
        bus.exmem_reg_write = 1; bus.exmem_rd = 3; bus.exmem_result = 32'hAA;
        bus.memwb_reg_write = 1; bus.memwb_rd = 3; bus.memwb_result = 32'hBB;
        #1 chk_all();
        chk("fwd_prio_op1", bus.op1, FWD ? 32'hAA : 32'h11);
        chk("fwd_prio_op2", bus.op2, FWD ? 32'hAA : 32'h22);
        bus.exmem_reg_write = 0;
        #1 chk_all();
        chk("fwd_memwb_op1", bus.op1, FWD ? 32'hBB : 32'h11);
        bus.exmem_reg_write = 1; bus.exmem_rd = 0; bus.memwb_rd = 0;
        bus.id_valid = 1; bus.id_rs = 0; bus.id_rt = 0; bus.id_rs_data = 32'h55;
        step();
        #1 chk_all();
        chk("fwd_r0_op1", bus.op1, 32'h55);
        clear();
        step();

`ifdef FORWARDING_EN
        // Load-use: lw $5 in EX, consumer reads $5
        bus.id_valid = 1; bus.id_rs = 1; bus.id_rt = 5; bus.id_imm = 8; bus.id_alu_src = 1;
        bus.id_reg_write = 1; bus.id_mem_read = 1; bus.id_mem_to_reg = 1;
        step();
        bus.id_alu_src = 0; bus.id_mem_read = 0; bus.id_mem_to_reg = 0; bus.id_imm = 0;
        bus.id_alu_op = 2'b10; bus.id_funct = 6'b100000;
        bus.id_rs = 5; bus.id_rt = 2; bus.id_rd = 6; bus.id_reg_dst = 1;
        #1 chk_all();
        chk("lu_stall", {31'd0, bus.hazard_stall}, 32'd1);
        step();
        bus.exmem_reg_write = 1; bus.exmem_rd = 5; bus.exmem_result = 32'h1234;
        #1 chk_all();
        chk("lu_bubble", {31'd0, bus.ex_valid}, 32'd0);
        chk("lu_stall_gone", {31'd0, bus.hazard_stall}, 32'd0);
        step();
        bus.exmem_reg_write = 0; bus.id_valid = 0;
        bus.memwb_reg_write = 1; bus.memwb_rd = 5; bus.memwb_result = 32'hCAFE;
        #1 chk_all();
        chk("lu_valid", {31'd0, bus.ex_valid}, 32'd1);
        chk("lu_op1", bus.op1, 32'hCAFE);
`else
        // RAW without bypass: stall until the writer leaves EX/MEM
        bus.id_valid = 1; bus.id_rs = 1; bus.id_rt = 3; bus.id_rd = 2; bus.id_reg_dst = 1; bus.id_reg_write = 1;
        step();
        bus.id_rs = 2; bus.id_rt = 3; bus.id_rd = 4;
        #1 chk_all();
        chk("raw_stall_ex", {31'd0, bus.hazard_stall}, 32'd1);
        step();
        bus.exmem_reg_write = 1; bus.exmem_rd = 2; bus.exmem_result = 32'h66;
        #1 chk_all();
        chk("raw_stall_exmem", {31'd0, bus.hazard_stall}, 32'd1);
        chk("raw_bubble", {31'd0, bus.ex_valid}, 32'd0);
        step();
        bus.exmem_reg_write = 0; bus.memwb_reg_write = 1; bus.memwb_rd = 2; bus.memwb_result = 32'h66;
        bus.id_rs_data = 32'h77;
        #1 chk_all();
        chk("raw_release", {31'd0, bus.hazard_stall}, 32'd0);
        step();
        bus.id_valid = 0;
        #1 chk_all();
        chk("raw_valid", {31'd0, bus.ex_valid}, 32'd1);
        chk("raw_op1", bus.op1, 32'h77);
`endif
        clear();
        step();

        // Hold for three cycles while ID keeps changing
        bus.id_valid = 1; bus.id_alu_op = 2'b11; bus.id_rs = 1; bus.id_rd = 7; bus.id_reg_dst = 1; bus.id_reg_write = 1;
        step();
        bus.hold = 1;
        for (int i = 0; i < 3; i++) begin
            bus.id_alu_op = 2'($urandom_range(0, 3)); bus.id_rd = 5'($urandom_range(8, 31));
            bus.id_rs_data = $urandom;
            step();
            chk_all();
            chk("hold_valid", {31'd0, bus.ex_valid}, 32'd1);
            chk("hold_selection", {26'd0, bus.selection}, 32'b101010);
            chk("hold_dest", {27'd0, bus.ex_dest}, 32'd7);
        end

        // flush beats hold
        bus.flush = 1;
        step();
        chk_all();
        chk("flush_hold_valid", {31'd0, bus.ex_valid}, 32'd0);
        chk("flush_hold_rw", {31'd0, bus.ex_reg_write}, 32'd0);
        clear();

        // Mid-stream asynchronous reset
        bus.id_valid = 1; bus.id_alu_op = 2'b01; bus.id_rs = 2; bus.id_rs_data = 32'h1234;
        step();
        clear();
        #1 chk("pre_reset_valid", {31'd0, bus.ex_valid}, 32'd1);
        rst = 1'b1;
        model_reset();
        #1;
        chk("areset_valid", {31'd0, bus.ex_valid}, 32'd0);
        chk("areset_selection", {26'd0, bus.selection}, 32'b100000);
        chk_all();
        #1 rst = 1'b0;

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            bus.hold = ($urandom_range(0, 7) == 0);
            bus.flush = ($urandom_range(0, 9) == 0);
            bus.id_valid = ($urandom_range(0, 4) != 0);
            bus.id_rs_data = $urandom; bus.id_rt_data = $urandom; bus.id_imm = $urandom;
            bus.id_rs = 5'($urandom_range(0, 3)); bus.id_rt = 5'($urandom_range(0, 3));
            bus.id_rd = 5'($urandom_range(0, 3));
            bus.id_funct = 6'($urandom_range(0, 63)); bus.id_alu_op = 2'($urandom_range(0, 3));
            bus.id_alu_src = 1'($urandom_range(0, 1)); bus.id_reg_dst = 1'($urandom_range(0, 1));
            bus.id_reg_write = 1'($urandom_range(0, 1)); bus.id_mem_read = ($urandom_range(0, 2) == 0);
            bus.id_mem_write = 1'($urandom_range(0, 1)); bus.id_mem_to_reg = 1'($urandom_range(0, 1));
            bus.exmem_reg_write = 1'($urandom_range(0, 1)); bus.exmem_rd = 5'($urandom_range(0, 3));
            bus.exmem_result = $urandom;
            bus.memwb_reg_write = 1'($urandom_range(0, 1)); bus.memwb_rd = 5'($urandom_range(0, 3));
            bus.memwb_result = $urandom;
            #1 chk_all();
            step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
